// File: rtl/slow_countdown.sv
// Loadable, pausable countdown timer stepped by edges of an asynchronous slow level.
// The slow level is resynchronised into clk; every TICKS_PER_STEP detected edges decrement count while running.
module slow_countdown #(
    parameter int WIDTH          = 8,
    parameter bit BOTH_EDGES     = 1'b0,
    parameter int TICKS_PER_STEP = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             slow_clk,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             expired,
    output logic             done,
    output logic             tick
);

    // state   | meaning
    // IDLE    | loaded or reset, waiting for start
    // RUN     | counting down on ticks
    // PAUSED  | count and prescaler frozen until start
    // EXPIRED | count reached 0, only load or reset leaves

    localparam int PW = $clog2(TICKS_PER_STEP + 1);
    localparam logic [PW-1:0] PS_LAST = PW'(TICKS_PER_STEP - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t        state;
    logic          s1, s2, s3;
    logic [1:0]    warm_cnt;
    logic          warm;
    logic          slow_edge;
    logic [PW-1:0] prescaler;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= slow_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Hides the false edge seen while the chain fills with an already-high slow_clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm_cnt <= 2'd0;
        end else if (warm_cnt != 2'd3) begin
            warm_cnt <= warm_cnt + 2'd1;
        end
    end

    assign warm      = (warm_cnt == 2'd3);
    assign slow_edge = BOTH_EDGES ? (s2 ^ s3) : (s2 & ~s3);
    assign tick      = slow_edge & warm;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            count     <= '0;
            prescaler <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                count     <= load_val;
                prescaler <= '0;
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (count != '0) begin
                                state     <= RUN;
                                prescaler <= '0;
                            end else begin
                                state <= EXPIRED;
                                done  <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        // A tick coinciding with stop is intentionally lost.
                        if (stop) begin
                            state <= PAUSED;
                        end else if (tick) begin
                            if (prescaler == PS_LAST) begin
                                prescaler <= '0;
                                if (count != '0) begin
                                    count <= count - WIDTH'(1);
                                    if (count == WIDTH'(1)) begin
                                        state <= EXPIRED;
                                        done  <= 1'b1;
                                    end
                                end
                            end else begin
                                prescaler <= prescaler + PW'(1);
                            end
                        end
                    end
                    PAUSED: begin
                        if (start) begin
                            state <= RUN;
                        end
                    end
                    EXPIRED: begin
                        count <= '0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign running = (state == RUN);
    assign expired = (state == EXPIRED);

endmodule

// File: tb/tb_slow_countdown.sv
// Scoreboard bench for slow_countdown: stimulus queues expected output changes,
// per-DUT monitors pop and compare whenever count/running/expired/done change.
module tb_slow_countdown;

    typedef struct {
        logic [7:0] count;
        logic       running;
        logic       expired;
        logic       done;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         tick_cnt0 = 0;
    int         tick_cnt1 = 0;
    exp_t       q0[$];
    exp_t       q1[$];

    logic       slow0, load0, start0, stop0;
    logic [7:0] lv0;
    logic [7:0] count0;
    logic       run0, exp0, done0, tick0;

    logic       slow1, load1, start1, stop1;
    logic [7:0] lv1;
    logic [7:0] count1;
    logic       run1, exp1, done1, tick1;

    slow_countdown #(.WIDTH(8), .BOTH_EDGES(1'b0), .TICKS_PER_STEP(1)) dut0 (
        .clk(clk), .reset_n(rst_n), .slow_clk(slow0), .load(load0), .load_val(lv0),
        .start(start0), .stop(stop0), .count(count0), .running(run0),
        .expired(exp0), .done(done0), .tick(tick0)
    );

    slow_countdown #(.WIDTH(8), .BOTH_EDGES(1'b1), .TICKS_PER_STEP(2)) dut1 (
        .clk(clk), .reset_n(rst_n), .slow_clk(slow1), .load(load1), .load_val(lv1),
        .start(start1), .stop(stop1), .count(count1), .running(run1),
        .expired(exp1), .done(done1), .tick(tick1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic compare_evt(input int d, input logic [10:0] cur);
        exp_t e;
        n_checks++;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_errors++;
            $display("FAIL dut%0d unexpected change: count=%0d run=%0b exp=%0b done=%0b cyc=%0d",
                     d, cur[10:3], cur[2], cur[1], cur[0], cyc);
            return;
        end
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        if (cur[10:3] != e.count || cur[2] != e.running || cur[1] != e.expired ||
            cur[0] != e.done || (e.cyc >= 0 && e.cyc != cyc)) begin
            n_errors++;
            $display("FAIL dut%0d event: got count=%0d run=%0b exp=%0b done=%0b cyc=%0d, want count=%0d run=%0b exp=%0b done=%0b cyc=%0d",
                     d, cur[10:3], cur[2], cur[1], cur[0], cyc,
                     e.count, e.running, e.expired, e.done, e.cyc);
        end
    endtask

    initial begin : mon0
        logic [10:0] prev, cur;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {count0, run0, exp0, done0};
            if (!rst_n) begin
                prev = '0;
            end else begin
                if (tick0) tick_cnt0++;
                if (cur != prev) begin
                    compare_evt(0, cur);
                    prev = cur;
                end
            end
        end
    end

    initial begin : mon1
        logic [10:0] prev, cur;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {count1, run1, exp1, done1};
            if (!rst_n) begin
                prev = '0;
            end else begin
                if (tick1) tick_cnt1++;
                if (cur != prev) begin
                    compare_evt(1, cur);
                    prev = cur;
                end
            end
        end
    end

    task automatic push0(input int c, input logic r, input logic x, input logic dn, input int cy);
        exp_t e;
        e.count = 8'(c); e.running = r; e.expired = x; e.done = dn; e.cyc = cy;
        q0.push_back(e);
    endtask

    task automatic push1(input int c, input logic r, input logic x, input logic dn, input int cy);
        exp_t e;
        e.count = 8'(c); e.running = r; e.expired = x; e.done = dn; e.cyc = cy;
        q1.push_back(e);
    endtask

    // All stimulus tasks start and end just after a falling clock edge.
    task automatic load_0(input int v);
        lv0 = 8'(v); load0 = 1'b1; @(negedge clk); load0 = 1'b0;
    endtask
    task automatic start_0();
        start0 = 1'b1; @(negedge clk); start0 = 1'b0;
    endtask
    task automatic stop_0();
        stop0 = 1'b1; @(negedge clk); stop0 = 1'b0;
    endtask
    task automatic rise_0();
        slow0 = 1'b1; repeat (4) @(negedge clk);
        slow0 = 1'b0; repeat (4) @(negedge clk);
    endtask
    task automatic load_1(input int v);
        lv1 = 8'(v); load1 = 1'b1; @(negedge clk); load1 = 1'b0;
    endtask
    task automatic start_1();
        start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    endtask
    task automatic toggle_1();
        slow1 = ~slow1; repeat (4) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, want < 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        rst_n = 1'b0;
        slow0 = 1'b1; load0 = 1'b0; start0 = 1'b0; stop0 = 1'b0; lv0 = '0;
        slow1 = 1'b0; load1 = 1'b0; start1 = 1'b0; stop1 = 1'b0; lv1 = '0;
        repeat (3) @(negedge clk);

        // Release reset with slow_clk already high: no tick may appear.
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("warmup tick", int'(tick0), 0);
        end
        check("reset count", int'(count0), 0);
        check("reset running", int'(run0), 0);
        check("reset expired", int'(exp0), 0);
        check("reset done", int'(done0), 0);
        slow0 = 1'b0;
        repeat (4) @(negedge clk);
        check("warmup tick total", tick_cnt0, 0);

        // Load 3, run down to expiry with cycle-exact updates.
        push0(3, 0, 0, 0, -1); load_0(3);
        push0(3, 1, 0, 0, -1); start_0();
        n = cyc; push0(2, 1, 0, 0, n + 3); rise_0();
        n = cyc; push0(1, 1, 0, 0, n + 3); rise_0();
        n = cyc; push0(0, 0, 1, 1, n + 3); push0(0, 0, 1, 0, n + 4); rise_0();
        check("ticks after countdown", tick_cnt0, 3);

        // Stop coinciding with the second tick drops that tick.
        push0(5, 0, 0, 0, -1); load_0(5);
        push0(5, 1, 0, 0, -1); start_0();
        n = cyc; push0(4, 1, 0, 0, n + 3); rise_0();
        n = cyc; push0(4, 0, 0, 0, n + 3);
        slow0 = 1'b1;
        repeat (2) @(negedge clk);
        stop_0();
        repeat (1) @(negedge clk);
        slow0 = 1'b0; repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) rise_0();
        push0(4, 1, 0, 0, -1); start_0();
        n = cyc; push0(3, 1, 0, 0, n + 3); rise_0();
        check("ticks after pause", tick_cnt0, 10);

        // Start from IDLE with zero count expires immediately; stop/start ignored there.
        push0(0, 0, 0, 0, -1); load_0(0);
        n = cyc; push0(0, 0, 1, 1, n + 1); push0(0, 0, 1, 0, n + 2); start_0();
        repeat (2) @(negedge clk);
        stop_0(); start_0(); rise_0();
        push0(7, 0, 0, 0, -1); load_0(7);

        // Two-edge prescaled instance: decrement every second toggle.
        push1(2, 0, 0, 0, -1); load_1(2);
        push1(2, 1, 0, 0, -1); start_1();
        toggle_1();
        n = cyc; push1(1, 1, 0, 0, n + 3); toggle_1();
        toggle_1();
        n = cyc; push1(0, 0, 1, 1, n + 3); push1(0, 0, 1, 0, n + 4); toggle_1();
        repeat (4) @(negedge clk);
        check("dut1 ticks", tick_cnt1, 4);

        // Load wins over a simultaneous start while running.
        push0(7, 1, 0, 0, -1); start_0();
        n = cyc; push0(6, 1, 0, 0, n + 3); rise_0();
        push0(9, 0, 0, 0, -1);
        lv0 = 8'd9; load0 = 1'b1; start0 = 1'b1;
        @(negedge clk);
        load0 = 1'b0; start0 = 1'b0;
        repeat (2) @(negedge clk);
        push0(9, 1, 0, 0, -1); start_0();
        repeat (2) @(negedge clk);
        check("ticks before reset", tick_cnt0, 12);

        // Asynchronous reset mid-run clears everything without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("async count", int'(count0), 0);
        check("async running", int'(run0), 0);
        check("async expired", int'(exp0), 0);
        check("async done", int'(done0), 0);
        check("async dut1 expired", int'(exp1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        check("dut0 pending events", q0.size(), 0);
        check("dut1 pending events", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
